ps2_key_matrix: RTL and testbench
=================================

Name: ps2_key_matrix

Overview:
Parametrised successor to the fixed-table PS/2 keyboard matrix. It consumes the raw PS/2 byte stream and decodes the E0 (extended), F0 (break) and E1 (Pause) prefixes itself. Scancodes are mapped to matrix positions through a host-loadable map RAM, so one block serves any ROWS x COLS machine keyboard. It sits between the PS/2 receiver and the machine's keyboard-row read port, and also provides two latched hotkey outputs (reset, cassette).

Parameters:
ROWS, 10, number of matrix rows (1..16)
COLS, 8, bits per row (1..8)
ROW_W, 4, width of row select and map row field
COL_W, 3, width of map column field
HOTKEY0, 8'h0A, non-extended scancode driving hk0 (F8)
HOTKEY1, 8'h01, non-extended scancode driving hk1 (F9)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
kb_data  in  8  received PS/2 byte
kb_strobe  in  1  one-cycle pulse, kb_data valid
map_we  in  1  map RAM write enable
map_addr  in  9  {extended, scancode}
map_data  in  1+ROW_W+COL_W  {valid, row, col}
row  in  ROW_W  matrix row select
q  out  COLS  row state, active-low (0 = pressed)
hk0  out  1  high while HOTKEY0 held
hk1  out  1  high while HOTKEY1 held
busy  out  1  high while a prefix or Pause sequence is in progress

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all matrix bits 1, hk0=hk1=0, FSM IDLE, pause counter 0, pipeline valid 0, busy=0. Map RAM contents are not affected by reset.
- Prefix FSM, advanced only on kb_strobe:
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with cnt=7; AA/00/FF -> release-all; any other byte -> issue make(ext=0, code).
  - EXT: F0 -> EXTBRK; E0 -> stay in EXT; other -> make(ext=1, code), then IDLE.
  - BRK: issue break(ext=0, code), then IDLE.
  - EXTBRK: issue break(ext=1, code), then IDLE.
  - PAUSE: decrement cnt on each byte; return to IDLE when cnt reaches 0. Bytes in PAUSE have no other effect.
- E0 12 / E0 F0 12 (fake shift) map through the extended page like any other code. To ignore them, leave map entry 0x112 invalid.
- busy = (state != IDLE).
- Pipeline:
  - Strobe sampled at edge N: FSM registers the action and map address.
  - Edge N+1: synchronous map RAM read.
  - Edge N+2: matrix bit written (make -> 0, break -> 1).
  - One strobe per cycle is sustained.
- Map entry ignored (no matrix change) if valid=0, row>=ROWS or col>=COLS. Several scancodes may map to the same bit; last event wins.
- Hotkeys: non-extended HOTKEY0/HOTKEY1 make/break set/clear hk0/hk1 at edge N+1, independent of map contents.
- Release-all: at edge N+1 all matrix bits go to 1 and hk0=hk1=0. An in-flight map write at N+2 is suppressed.
- Typematic repeat (repeated make) is idempotent. Break of a non-pressed key is idempotent.
- Map write: map_we at edge M updates the entry. A lookup reading the same address in the same cycle returns the old data.
- q = matrix[row], combinational. row>=ROWS gives all ones.
- Reset mid-sequence (e.g. after E0): FSM returns to IDLE and the pending action is dropped.
- Simultaneous reset and kb_strobe: reset wins and the byte is discarded.

Test Plan:
1. Load 0x016 -> {1,0,0}. Send 16. q at row=0 = FE exactly 2 cycles after the strobe edge. Send F0 16 -> q=FF.
2. Load 0x075 -> {1,0,4} and 0x175 -> {1,9,4}. Send E0 75 -> row9 q=EF, row0 q=FF, busy high for exactly one byte. Send E0 F0 75 -> row9 q=FF.
3. Send E1 14 77 E1 F0 14 F0 77 followed by 16 -> no matrix change during the 8 Pause bytes, then row0 bit0 pressed. busy=0 after the 8th byte.
4. Press 16 and 1C (map 0x01C -> {1,2,5}), then send AA -> all rows FF. Press 0A -> hk0=1, matrix unchanged. Send F0 0A -> hk0=0.
5. Send E0, then assert reset, then send 16 -> non-extended make of 16 (row0 q=FE). The dropped E0 has no effect.
6. Map 0x02E -> {1,12,0} with ROWS=10 -> no change. Send 2E back-to-back with a map_we to 0x02E in the same cycle -> old entry is used. row=15 -> q=FF.

Source files
------------

// File: rtl/ps2_key_matrix.sv
// ps2_key_matrix: PS/2 byte stream to ROWS x COLS keyboard matrix.
// Decodes the E0 / F0 / E1 prefixes and maps each scancode to a matrix bit
// through a host-loadable map RAM. Also provides two latched hotkeys.
// Pipeline: byte at edge N -> map read at N+1 -> matrix bit written at N+2.
module ps2_key_matrix #(
    parameter int          ROWS    = 10,
    parameter int          COLS    = 8,
    parameter int          ROW_W   = 4,
    parameter int          COL_W   = 3,
    parameter logic [7:0]  HOTKEY0 = 8'h0A,
    parameter logic [7:0]  HOTKEY1 = 8'h01
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               kb_data,
    input  logic                     kb_strobe,
    input  logic                     map_we,
    input  logic [8:0]               map_addr,
    input  logic [ROW_W+COL_W:0]     map_data,
    input  logic [ROW_W-1:0]         row,
    output logic [COLS-1:0]          q,
    output logic                     hk0,
    output logic                     hk1,
    output logic                     busy
);

    localparam int MAP_W = 1 + ROW_W + COL_W;

    // One extra bit so that ROWS = 2**ROW_W (and likewise COLS) is representable.
    localparam logic [ROW_W:0] ROWS_LIM = (ROW_W+1)'(ROWS);
    localparam logic [COL_W:0] COLS_LIM = (COL_W+1)'(COLS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK,
        ST_PAUSE
    } state_t;

    state_t            state_reg;
    logic [2:0]        pause_cnt_reg;

    // Stage 1: decoded key action and its map address.
    logic              act_valid_reg;
    logic              act_break_reg;
    logic              act_relall_reg;
    logic [8:0]        act_addr_reg;

    // Stage 2: map entry read back for that action.
    logic              look_valid_reg;
    logic              look_break_reg;
    logic [MAP_W-1:0]  map_rd_reg;

    logic [MAP_W-1:0]  map_ram [512];

    logic              hk0_reg;
    logic              hk1_reg;

    logic              ent_valid;
    logic [ROW_W-1:0]  ent_row;
    logic [COL_W-1:0]  ent_col;
    logic              row_ok;
    logic              col_ok;
    logic              wr_en;
    logic [COLS-1:0]   col_mask;
    logic [COLS-1:0]   row_bits [ROWS];

    // Prefix decoder: turns the byte stream into make / break / release-all actions.
    always_ff @(posedge clock) begin
        act_valid_reg  <= 1'b0;
        act_relall_reg <= 1'b0;
        if (reset) begin
            state_reg     <= ST_IDLE;
            pause_cnt_reg <= 3'd0;
            act_break_reg <= 1'b0;
            act_addr_reg  <= 9'd0;
        end else if (kb_strobe) begin
            case (state_reg)
                ST_IDLE: begin
                    if (kb_data == 8'hE0) begin
                        state_reg <= ST_EXT;
                    end else if (kb_data == 8'hF0) begin
                        state_reg <= ST_BRK;
                    end else if (kb_data == 8'hE1) begin
                        state_reg     <= ST_PAUSE;
                        pause_cnt_reg <= 3'd7;
                    end else if (kb_data == 8'hAA || kb_data == 8'h00 || kb_data == 8'hFF) begin
                        act_relall_reg <= 1'b1;
                    end else begin
                        act_valid_reg <= 1'b1;
                        act_break_reg <= 1'b0;
                        act_addr_reg  <= {1'b0, kb_data};
                    end
                end
                ST_EXT: begin
                    if (kb_data == 8'hF0) begin
                        state_reg <= ST_EXTBRK;
                    end else if (kb_data != 8'hE0) begin
                        act_valid_reg <= 1'b1;
                        act_break_reg <= 1'b0;
                        act_addr_reg  <= {1'b1, kb_data};
                        state_reg     <= ST_IDLE;
                    end
                end
                ST_BRK: begin
                    act_valid_reg <= 1'b1;
                    act_break_reg <= 1'b1;
                    act_addr_reg  <= {1'b0, kb_data};
                    state_reg     <= ST_IDLE;
                end
                ST_EXTBRK: begin
                    act_valid_reg <= 1'b1;
                    act_break_reg <= 1'b1;
                    act_addr_reg  <= {1'b1, kb_data};
                    state_reg     <= ST_IDLE;
                end
                ST_PAUSE: begin
                    // Pause bytes are swallowed; the count only tracks the sequence length.
                    pause_cnt_reg <= pause_cnt_reg - 3'd1;
                    if (pause_cnt_reg <= 3'd1) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg != ST_IDLE);

    // Host write port of the map RAM.
    always_ff @(posedge clock) begin
        if (map_we) begin
            map_ram[map_addr] <= map_data;
        end
    end

    // Registered map lookup; a same-edge host write is not visible here (read-first).
    always_ff @(posedge clock) begin
        map_rd_reg <= map_ram[act_addr_reg];
    end

    // Carry the action qualifiers alongside the RAM read.
    always_ff @(posedge clock) begin
        if (reset) begin
            look_valid_reg <= 1'b0;
            look_break_reg <= 1'b0;
        end else begin
            look_valid_reg <= act_valid_reg;
            look_break_reg <= act_break_reg;
        end
    end

    // Hotkeys follow non-extended make/break of their scancode, cleared by release-all.
    always_ff @(posedge clock) begin
        if (reset || act_relall_reg) begin
            hk0_reg <= 1'b0;
            hk1_reg <= 1'b0;
        end else if (act_valid_reg && !act_addr_reg[8]) begin
            if (act_addr_reg[7:0] == HOTKEY0) begin
                hk0_reg <= !act_break_reg;
            end
            if (act_addr_reg[7:0] == HOTKEY1) begin
                hk1_reg <= !act_break_reg;
            end
        end
    end

    assign hk0 = hk0_reg;
    assign hk1 = hk1_reg;

    // Map entry layout is {valid, row, col}.
    assign ent_valid = map_rd_reg[MAP_W-1];
    assign ent_row   = map_rd_reg[COL_W +: ROW_W];
    assign ent_col   = map_rd_reg[COL_W-1:0];
    assign row_ok    = ({1'b0, ent_row} < ROWS_LIM);
    assign col_ok    = ({1'b0, ent_col} < COLS_LIM);

    // A release-all landing on the same edge overrides the pending bit write.
    assign wr_en = look_valid_reg && ent_valid && row_ok && col_ok && !act_relall_reg;

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            assign col_mask[gi] = (ent_col == COL_W'(gi));
        end

        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic [COLS-1:0] bits_reg;

            // One matrix row: active-low key bits, break sets and make clears.
            always_ff @(posedge clock) begin
                if (reset || act_relall_reg) begin
                    bits_reg <= '1;
                end else if (wr_en && (ent_row == ROW_W'(gi))) begin
                    if (look_break_reg) begin
                        bits_reg <= bits_reg | col_mask;
                    end else begin
                        bits_reg <= bits_reg & ~col_mask;
                    end
                end
            end

            assign row_bits[gi] = bits_reg;
        end
    endgenerate

    // Row read port: unpopulated row selects read as no keys pressed.
    always_comb begin
        q = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (row == ROW_W'(r)) begin
                q = row_bits[r];
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Testbench for ps2_key_matrix: directed scenarios plus randomized traffic,
// all checked every cycle against an event-level model of the keyboard.
module tb_ps2_key_matrix;

    localparam int ROWS  = 10;
    localparam int COLS  = 8;
    localparam int ROW_W = 4;
    localparam int COL_W = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_strobe = 1'b0;
    logic       map_we = 1'b0;
    logic [8:0] map_addr = 9'd0;
    logic [7:0] map_data = 8'h00;
    logic [3:0] row = 4'd0;
    logic [7:0] q;
    logic       hk0;
    logic       hk1;
    logic       busy;

    ps2_key_matrix #(
        .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
        .HOTKEY0(8'h0A), .HOTKEY1(8'h01)
    ) dut (
        .clock(clock), .reset(reset), .kb_data(kb_data), .kb_strobe(kb_strobe),
        .map_we(map_we), .map_addr(map_addr), .map_data(map_data), .row(row),
        .q(q), .hk0(hk0), .hk1(hk1), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int       due;
        bit       rel;
        bit       brk;
        bit       ext;
        bit [7:0] code;
    } a_t;

    typedef struct {
        int       due;
        bit [7:0] ent;
        bit       brk;
    } b_t;

    bit [7:0] m_map [512];
    bit [7:0] m_mat [16];
    bit       m_hk0, m_hk1;
    bit       m_ext, m_brk;
    int       m_pause;
    int       ecnt = 0;
    a_t       qa[$];
    b_t       qb[$];
    bit       check_en = 1'b0;

    function automatic void m_push(input bit rel, input bit brk, input bit ext, input bit [7:0] b);
        qa.push_back('{ecnt + 1, rel, brk, ext, b});
    endfunction

    // Keyboard protocol rules applied to one received byte.
    function automatic void m_byte(input bit [7:0] b);
        if (m_pause > 0) begin
            m_pause--;
        end else if (m_brk) begin
            m_push(1'b0, 1'b1, m_ext, b);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b != 8'hE0) begin
                m_push(1'b0, 1'b0, 1'b1, b);
                m_ext = 1'b0;
            end
        end else begin
            case (b)
                8'hE0: m_ext = 1'b1;
                8'hF0: m_brk = 1'b1;
                8'hE1: m_pause = 7;
                8'hAA, 8'h00, 8'hFF: m_push(1'b1, 1'b0, 1'b0, b);
                default: m_push(1'b0, 1'b0, 1'b0, b);
            endcase
        end
    endfunction

    // Model advances on each edge: effects due at +1 (hotkeys, release-all, lookup)
    // and +2 (matrix bit), then the host map write, then the new byte.
    always @(posedge clock) begin : model
        a_t it;
        b_t bt;
        bit rel_now;
        ecnt++;
        if (reset) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
            m_pause = 0;
            qa.delete();
            qb.delete();
            for (int r = 0; r < 16; r++) m_mat[r] = 8'hFF;
            m_hk0 = 1'b0;
            m_hk1 = 1'b0;
        end else begin
            rel_now = 1'b0;
            while (qa.size() > 0 && qa[0].due == ecnt) begin
                it = qa.pop_front();
                if (it.rel) begin
                    rel_now = 1'b1;
                    for (int r = 0; r < 16; r++) m_mat[r] = 8'hFF;
                    m_hk0 = 1'b0;
                    m_hk1 = 1'b0;
                end else begin
                    if (!it.ext && it.code == 8'h0A) m_hk0 = !it.brk;
                    if (!it.ext && it.code == 8'h01) m_hk1 = !it.brk;
                    qb.push_back('{ecnt + 1, m_map[{it.ext, it.code}], it.brk});
                end
            end
            while (qb.size() > 0 && qb[0].due == ecnt) begin
                bt = qb.pop_front();
                if (!rel_now && bt.ent[7] && int'(bt.ent[6:3]) < ROWS && int'(bt.ent[2:0]) < COLS)
                    m_mat[bt.ent[6:3]][bt.ent[2:0]] = bt.brk;
            end
            if (kb_strobe) m_byte(kb_data);
        end
        if (map_we) m_map[map_addr] = map_data;
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (check_en) begin
            logic [7:0] exp_q;
            logic       exp_busy;
            exp_q    = (int'(row) < ROWS) ? m_mat[row] : 8'hFF;
            exp_busy = m_ext || m_brk || (m_pause > 0);
            n_checks++;
            if ({q, hk0, hk1, busy} === {exp_q, m_hk0, m_hk1, exp_busy}) n_pass++;
            else $display("FAIL model t=%0t row=%0d: got q=%h hk0=%b hk1=%b busy=%b expected q=%h hk0=%b hk1=%b busy=%b",
                          $time, row, q, hk0, hk1, busy, exp_q, m_hk0, m_hk1, exp_busy);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #2;
        kb_strobe = 1'b0;
        map_we    = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        kb_data   = b;
        kb_strobe = 1'b1;
        tick();
    endtask

    task automatic load(input int addr, input logic [7:0] e);
        map_addr = 9'(addr);
        map_data = e;
        map_we   = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic set_row(input int r);
        row = 4'(r);
        #1;
    endtask

    function automatic logic [7:0] ent(input bit v, input int r, input int c);
        return {v, 4'(r), 3'(c)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pz [8];
        int p;
        logic [7:0] b;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        check_en = 1'b1;

        set_row(0);
        check("reset_q_row0", q, 8'hFF);
        check("reset_hk0", {7'd0, hk0}, 8'h00);
        check("reset_hk1", {7'd0, hk1}, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'h00);

        for (int a = 0; a < 512; a++) load(a, 8'h00);

        // 1: make / break latency
        load(9'h016, ent(1, 0, 0));
        send(8'h16);
        check("t1_q_edgeN", q, 8'hFF);
        tick();
        check("t1_q_edgeN1", q, 8'hFF);
        tick();
        check("t1_q_edgeN2", q, 8'hFE);
        send(8'hF0);
        send(8'h16);
        idle(2);
        check("t1_break", q, 8'hFF);

        // 2: extended page
        load(9'h075, ent(1, 0, 4));
        load(9'h175, ent(1, 9, 4));
        send(8'hE0);
        check("t2_busy_e0", {7'd0, busy}, 8'h01);
        send(8'h75);
        check("t2_busy_done", {7'd0, busy}, 8'h00);
        idle(2);
        set_row(9);
        check("t2_row9", q, 8'hEF);
        set_row(0);
        check("t2_row0", q, 8'hFF);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        idle(2);
        set_row(9);
        check("t2_row9_break", q, 8'hFF);

        // 3: Pause sequence is inert
        set_row(0);
        pz = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) begin
            send(pz[i]);
            check($sformatf("t3_busy_%0d", i), {7'd0, busy}, (i < 7) ? 8'h01 : 8'h00);
        end
        idle(2);
        check("t3_no_change", q, 8'hFF);
        send(8'h16);
        idle(2);
        check("t3_after_pause", q, 8'hFE);

        // 4: release-all and hotkeys
        load(9'h01C, ent(1, 2, 5));
        send(8'h1C);
        idle(2);
        set_row(2);
        check("t4_row2", q, 8'hDF);
        send(8'hAA);
        tick();
        check("t4_relall_row2", q, 8'hFF);
        set_row(0);
        check("t4_relall_row0", q, 8'hFF);
        send(8'h0A);
        tick();
        check("t4_hk0_on", {7'd0, hk0}, 8'h01);
        tick();
        check("t4_hk0_matrix", q, 8'hFF);
        send(8'hF0);
        send(8'h0A);
        tick();
        check("t4_hk0_off", {7'd0, hk0}, 8'h00);
        send(8'h01);
        tick();
        check("t4_hk1_on", {7'd0, hk1}, 8'h01);
        send(8'hAA);
        tick();
        check("t4_hk1_relall", {7'd0, hk1}, 8'h00);
        send(8'h16);
        send(8'hAA);
        idle(3);
        check("t4_suppress", q, 8'hFF);
        send(8'hAA);
        send(8'h16);
        idle(2);
        check("t4_after_relall", q, 8'hFE);

        // 5: reset drops a pending prefix; reset beats a strobe
        load(9'h116, ent(1, 5, 3));
        send(8'hE0);
        reset = 1'b1;
        tick();
        check("t5_busy_reset", {7'd0, busy}, 8'h00);
        send(8'h16);
        idle(2);
        check("t5_row0", q, 8'hFE);
        set_row(5);
        check("t5_row5", q, 8'hFF);
        set_row(0);
        reset     = 1'b1;
        kb_data   = 8'h16;
        kb_strobe = 1'b1;
        tick();
        idle(3);
        check("t5_strobe_in_reset", q, 8'hFF);

        // 6: out-of-range entries, read-first map, unpopulated rows
        load(9'h02E, ent(1, 12, 0));
        send(8'h2E);
        idle(2);
        for (int r = 0; r < ROWS; r++) begin
            set_row(r);
            check($sformatf("t6_oob_row%0d", r), q, 8'hFF);
        end
        load(9'h02E, ent(1, 3, 1));
        kb_data   = 8'h2E;
        kb_strobe = 1'b1;
        tick();
        map_addr = 9'h02E;
        map_data = ent(1, 4, 2);
        map_we   = 1'b1;
        tick();
        tick();
        set_row(3);
        check("t6_old_entry_row3", q, 8'hFD);
        set_row(4);
        check("t6_old_entry_row4", q, 8'hFF);
        send(8'h2E);
        idle(2);
        check("t6_new_entry_row4", q, 8'hFB);
        set_row(15);
        check("t6_row15", q, 8'hFF);
        set_row(10);
        check("t6_row10", q, 8'hFF);

        // Randomized traffic
        for (int a = 0; a < 512; a++)
            load(a, ent($urandom_range(0, 3) != 0, $urandom_range(0, 11), $urandom_range(0, 7)));
        for (int n = 0; n < 3000; n++) begin
            row = 4'($urandom_range(0, 15));
            p = $urandom_range(0, 99);
            if (p < 70) begin
                p = $urandom_range(0, 99);
                if (p < 12) b = 8'hE0;
                else if (p < 22) b = 8'hF0;
                else if (p < 25) b = 8'hE1;
                else if (p < 27) b = (p == 25) ? 8'hAA : (($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
                else if (p < 35) b = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h01;
                else b = 8'($urandom_range(1, 127));
                kb_data   = b;
                kb_strobe = 1'b1;
            end
            if ($urandom_range(0, 99) < 3) begin
                map_addr = 9'($urandom_range(0, 511));
                map_data = ent($urandom_range(0, 1) != 0, $urandom_range(0, 11), $urandom_range(0, 7));
                map_we   = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            tick();
        end

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
